// File: rtl/shift_reg_seq_ctrl_pkg.sv
// Shared types and constants for the shift register sequencer.
package shift_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    SHIFT = 3'd2,
    DONE  = 3'd3,
    GAP   = 3'd4
  } state_t;

  localparam logic SR_MODE_HOLD   = 1'b0;
  localparam logic SR_MODE_RSHIFT = 1'b1;

  localparam int DEF_WIDTH      = 4;
  localparam int DEF_GAP_CYCLES = 1;
  localparam int DEF_ERR_W      = 8;

endpackage

// File: rtl/shift_reg_seq_ctrl_if.sv
// Word-source handshake, shift register drive/return and result signals.
interface shift_reg_seq_ctrl_if import shift_ctrl_pkg::*; #(
  parameter int WIDTH = DEF_WIDTH,
  parameter int ERR_W = DEF_ERR_W
) ();
  logic             in_valid;
  logic [WIDTH-1:0] in_data;
  logic             in_ready;
  logic             sr_load;
  logic             sr_mode;
  logic [WIDTH-1:0] sr_d;
  logic             sr_q;
  logic             out_valid;
  logic [WIDTH-1:0] out_data;
  logic             err;
  logic [ERR_W-1:0] err_cnt;
  logic             busy;

  modport master (
    output in_valid, in_data, sr_q,
    input  in_ready, sr_load, sr_mode, sr_d, out_valid, out_data, err, err_cnt, busy
  );

  modport slave (
    input  in_valid, in_data, sr_q,
    output in_ready, sr_load, sr_mode, sr_d, out_valid, out_data, err, err_cnt, busy
  );
endinterface

// File: rtl/shift_reg_seq_ctrl_shift_capture.sv
// Bit counter and LSB-first deserializer for the returning serial stream.
// Latency: one bit per enabled cycle; no backpressure, driven purely by the FSM.
// rx_word presents the word including the bit sampled this cycle.
module shift_capture import shift_ctrl_pkg::*; #(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             en,
  input  logic             sample,
  output logic             last_bit,
  output logic [WIDTH-1:0] rx_word
);
  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] rx_q, rx_d;

  always_comb begin
    cnt_d = cnt_q;
    rx_d  = rx_q;
    if (start) begin
      cnt_d = '0;
    end else if (en) begin
      rx_d[cnt_q] = sample;
      cnt_d       = cnt_q + CNT_W'(1);
    end
  end

  assign last_bit = en && (cnt_q == CNT_W'(WIDTH - 1));
  assign rx_word  = rx_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
      rx_q  <= '0;
    end else begin
      cnt_q <= cnt_d;
      rx_q  <= rx_d;
    end
  end
endmodule

// File: rtl/shift_reg_seq_ctrl.sv
// Loads each accepted word into the shift register, shifts it out and checks the echo.
// Latency: out_valid WIDTH+1 cycles after accept; one word per WIDTH+3+GAP_CYCLES cycles.
// Backpressure: in_ready only in IDLE; the source holds its word until accepted.
module shift_reg_seq_ctrl import shift_ctrl_pkg::*; #(
  parameter int WIDTH      = DEF_WIDTH,
  parameter int GAP_CYCLES = DEF_GAP_CYCLES,
  parameter int ERR_W      = DEF_ERR_W
) (
  input  logic                 clk,
  input  logic                 rst,
  shift_reg_seq_ctrl_if.slave  bus
);
  localparam int GAP_W    = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam int GAP_LAST = (GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0;

  state_t           state_q, state_d;
  logic [GAP_W-1:0] gap_cnt_q, gap_cnt_d;
  logic [WIDTH-1:0] tx_q, tx_d;
  logic [WIDTH-1:0] sr_d_q, sr_d_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic [ERR_W-1:0] err_cnt_q, err_cnt_d;
  logic             in_ready_q, in_ready_d;
  logic             sr_load_q, sr_load_d;
  logic             sr_mode_q, sr_mode_d;
  logic             out_valid_q, out_valid_d;
  logic             err_q, err_d;
  logic             busy_q, busy_d;
  logic             cap_start, cap_en, last_bit;
  logic [WIDTH-1:0] rx_word;

  shift_capture #(.WIDTH(WIDTH)) u_capture (
    .clk      (clk),
    .rst      (rst),
    .start    (cap_start),
    .en       (cap_en),
    .sample   (bus.sr_q),
    .last_bit (last_bit),
    .rx_word  (rx_word)
  );

  always_comb begin
    state_d   = state_q;
    gap_cnt_d = gap_cnt_q;
    tx_d      = tx_q;
    cap_start = 1'b0;
    cap_en    = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.in_valid && in_ready_q) begin
          tx_d    = bus.in_data;
          state_d = LOAD;
        end
      end
      LOAD: begin
        cap_start = 1'b1;
        state_d   = SHIFT;
      end
      SHIFT: begin
        cap_en = 1'b1;
        if (last_bit) state_d = DONE;
      end
      DONE: begin
        gap_cnt_d = '0;
        state_d   = (GAP_CYCLES == 0) ? IDLE : GAP;
      end
      GAP: begin
        if (gap_cnt_q == GAP_W'(GAP_LAST)) state_d = IDLE;
        else gap_cnt_d = gap_cnt_q + GAP_W'(1);
      end
      default: state_d = IDLE;
    endcase

    // Outputs are registered from the next state so reset forces them all low.
    in_ready_d  = (state_d == IDLE);
    busy_d      = (state_d != IDLE);
    sr_load_d   = (state_d == LOAD);
    sr_mode_d   = (state_d == SHIFT) ? SR_MODE_RSHIFT : SR_MODE_HOLD;
    sr_d_d      = tx_d;
    out_valid_d = (state_d == DONE);
    out_data_d  = out_valid_d ? rx_word : out_data_q;
    err_d       = out_valid_d && (rx_word != tx_q);
    err_cnt_d   = err_cnt_q;
    if (err_d && (err_cnt_q != '1)) err_cnt_d = err_cnt_q + ERR_W'(1);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      gap_cnt_q   <= '0;
      tx_q        <= '0;
      sr_d_q      <= '0;
      out_data_q  <= '0;
      err_cnt_q   <= '0;
      in_ready_q  <= 1'b0;
      sr_load_q   <= 1'b0;
      sr_mode_q   <= SR_MODE_HOLD;
      out_valid_q <= 1'b0;
      err_q       <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      gap_cnt_q   <= gap_cnt_d;
      tx_q        <= tx_d;
      sr_d_q      <= sr_d_d;
      out_data_q  <= out_data_d;
      err_cnt_q   <= err_cnt_d;
      in_ready_q  <= in_ready_d;
      sr_load_q   <= sr_load_d;
      sr_mode_q   <= sr_mode_d;
      out_valid_q <= out_valid_d;
      err_q       <= err_d;
      busy_q      <= busy_d;
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.sr_load   = sr_load_q;
  assign bus.sr_mode   = sr_mode_q;
  assign bus.sr_d      = sr_d_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.err       = err_q;
  assign bus.err_cnt   = err_cnt_q;
  assign bus.busy      = busy_q;
endmodule
